// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles and flush handling.
// In: id_* bundle, flush, hold. Out: ex_* bundle, load_use_stall, bubble_cnt.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [12:0]      id_ctrl,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [3:0]       id_func,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [12:0]      ex_ctrl,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [3:0]       ex_func,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [12:0] BUBBLE = 13'h0380;
  localparam int MEM_RD_BIT = 11;

  logic pend_flush;
  logic kill;
  logic rs1_hit;
  logic rs2_hit;
  logic do_hold;
  logic do_flush;
  logic do_stall;
  logic do_cap;
  logic cnt_sat;

  // A flush seen during hold is remembered and applied on release.
  assign kill = flush | pend_flush;

  assign rs1_hit = id_use_rs1 & (ex_rd == id_rs1);
  assign rs2_hit = id_use_rs2 & (ex_rd == id_rs2);

  assign load_use_stall = id_valid & ex_valid
                        & ex_ctrl[MEM_RD_BIT]
                        & (ex_rd != '0)
                        & (rs1_hit | rs2_hit)
                        & ~kill;

  assign do_hold  = hold;
  assign do_flush = ~hold & kill;
  assign do_stall = ~hold & load_use_stall;
  assign do_cap   = ~hold & ~kill
                  & ~load_use_stall;

  assign cnt_sat = &bubble_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= BUBBLE;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_func     <= '0;
      pend_flush  <= 1'b0;
    end else begin
      unique case (1'b1)
        do_hold: begin
          if (flush) pend_flush <= 1'b1;
        end
        do_flush, do_stall: begin
          ex_valid    <= 1'b0;
          ex_ctrl     <= BUBBLE;
          ex_pc       <= '0;
          ex_rs1_data <= '0;
          ex_rs2_data <= '0;
          ex_imm      <= '0;
          ex_rs1      <= '0;
          ex_rs2      <= '0;
          ex_rd       <= '0;
          ex_func     <= '0;
          pend_flush  <= 1'b0;
        end
        do_cap: begin
          ex_valid    <= id_valid;
          ex_ctrl     <= id_valid ? id_ctrl : BUBBLE;
          ex_pc       <= id_pc;
          ex_rs1_data <= id_rs1_data;
          ex_rs2_data <= id_rs2_data;
          ex_imm      <= id_imm;
          ex_rs1      <= id_rs1;
          ex_rs2      <= id_rs2;
          ex_rd       <= id_rd;
          ex_func     <= id_func;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bubble_cnt <= '0;
    end else if ((do_flush | do_stall) && !cnt_sat) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, load-use, flush, hold and reset.
// Drives id_* after each edge and samples ex_* 1ns after the rising edge.
module tb_id_ex_stage;

  localparam logic [12:0] BUB = 13'h0380;
  localparam logic [12:0] ADD = 13'h0101;
  localparam logic [12:0] LW  = 13'h0C05;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [12:0] id_ctrl;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [3:0]  id_func;
  logic        flush;
  logic        hold;
  logic        ex_valid;
  logic [12:0] ex_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_func;
  logic        load_use_stall;
  logic [15:0] bubble_cnt;

  int n_pass;
  int n_tot;
  logic [15:0] exp_cnt;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_func(id_func), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_func(ex_func), .load_use_stall(load_use_stall),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [12:0] c,
                     input logic [31:0] pc,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd);
    id_valid    = v;
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1      = r1;
    id_use_rs1  = u1;
    id_rs2      = r2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_rs1_data = pc + 32'h1000;
    id_rs2_data = pc + 32'h2000;
    id_imm      = pc + 32'h3000;
    id_func     = pc[5:2];
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    flush = 1'b0;
    hold = 1'b0;
    put(1'b0, 13'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #12;
    n_tot++;
    if (ex_ctrl !== BUB)
      $display("FAIL reset_ctrl got %h want %h", ex_ctrl, BUB);
    else n_pass++;
    n_tot++;
    if (bubble_cnt !== 16'd0)
      $display("FAIL reset_cnt got %0d want 0", bubble_cnt);
    else n_pass++;
    n_tot++;
    if (ex_valid !== 1'b0 || ex_pc !== 32'h0)
      $display("FAIL reset_fields got v=%b pc=%h want 0 0",
               ex_valid, ex_pc);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_capture();
    put(1'b1, ADD, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    step();
    n_tot++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd3)
      $display("FAIL capture got v=%b pc=%h rd=%0d want 1 100 3",
               ex_valid, ex_pc, ex_rd);
    else n_pass++;
    n_tot++;
    if (ex_ctrl[9:7] !== 3'b010 || ex_ctrl !== ADD)
      $display("FAIL capture_ctrl got %h want %h", ex_ctrl, ADD);
    else n_pass++;
    n_tot++;
    if (ex_imm !== 32'h3100 || ex_rs1_data !== 32'h1100)
      $display("FAIL capture_data got imm=%h rs1d=%h want 3100 1100",
               ex_imm, ex_rs1_data);
    else n_pass++;
  endtask

  task automatic test_idle();
    put(1'b0, ADD, 32'h180, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4);
    step();
    n_tot++;
    if (ex_valid !== 1'b0 || ex_ctrl !== BUB || bubble_cnt !== exp_cnt)
      $display("FAIL idle got v=%b ctrl=%h cnt=%0d want 0 %h %0d",
               ex_valid, ex_ctrl, bubble_cnt, BUB, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_load_use_rs1();
    put(1'b1, LW, 32'h104, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    step();
    put(1'b1, ADD, 32'h108, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6);
    n_tot++;
    if (load_use_stall !== 1'b1)
      $display("FAIL lu_stall got %b want 1", load_use_stall);
    else n_pass++;
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tot++;
    if (ex_valid !== 1'b0 || ex_ctrl !== BUB || ex_pc !== 32'h0)
      $display("FAIL lu_bubble got v=%b ctrl=%h pc=%h want 0 %h 0",
               ex_valid, ex_ctrl, ex_pc, BUB);
    else n_pass++;
    n_tot++;
    if (bubble_cnt !== exp_cnt)
      $display("FAIL lu_cnt got %0d want %0d", bubble_cnt, exp_cnt);
    else n_pass++;
    n_tot++;
    if (load_use_stall !== 1'b0)
      $display("FAIL lu_release got %b want 0", load_use_stall);
    else n_pass++;
    step();
    n_tot++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 ||
        ex_pc !== 32'h108)
      $display("FAIL lu_capture got v=%b rs1=%0d rd=%0d pc=%h want 1 5 6 108",
               ex_valid, ex_rs1, ex_rd, ex_pc);
    else n_pass++;
  endtask

  task automatic test_no_hazard();
    put(1'b1, LW, 32'h10c, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    step();
    put(1'b1, ADD, 32'h110, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7);
    n_tot++;
    if (load_use_stall !== 1'b0)
      $display("FAIL nh_x0 got %b want 0", load_use_stall);
    else n_pass++;
    step();
    put(1'b1, LW, 32'h114, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    step();
    put(1'b1, ADD, 32'h118, 5'd1, 1'b1, 5'd5, 1'b1, 5'd8);
    n_tot++;
    if (load_use_stall !== 1'b1)
      $display("FAIL nh_rs2_used got %b want 1", load_use_stall);
    else n_pass++;
    put(1'b1, ADD, 32'h118, 5'd1, 1'b1, 5'd5, 1'b0, 5'd8);
    n_tot++;
    if (load_use_stall !== 1'b0)
      $display("FAIL nh_rs2_unused got %b want 0", load_use_stall);
    else n_pass++;
    step();
    n_tot++;
    if (ex_pc !== 32'h118 || bubble_cnt !== exp_cnt)
      $display("FAIL nh_capture got pc=%h cnt=%0d want 118 %0d",
               ex_pc, bubble_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_hold();
    put(1'b1, ADD, 32'h200, 5'd2, 1'b1, 5'd3, 1'b1, 5'd9);
    hold = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    n_tot++;
    if (ex_pc !== 32'h118 || ex_valid !== 1'b1 || ex_rd !== 5'd8)
      $display("FAIL fh_frozen got pc=%h v=%b rd=%0d want 118 1 8",
               ex_pc, ex_valid, ex_rd);
    else n_pass++;
    n_tot++;
    if (bubble_cnt !== exp_cnt)
      $display("FAIL fh_cnt_hold got %0d want %0d", bubble_cnt, exp_cnt);
    else n_pass++;
    hold = 1'b0;
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tot++;
    if (ex_valid !== 1'b0 || ex_ctrl !== BUB || bubble_cnt !== exp_cnt)
      $display("FAIL fh_bubble got v=%b ctrl=%h cnt=%0d want 0 %h %0d",
               ex_valid, ex_ctrl, bubble_cnt, BUB, exp_cnt);
    else n_pass++;
    step();
    n_tot++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || bubble_cnt !== exp_cnt)
      $display("FAIL fh_capture got v=%b pc=%h cnt=%0d want 1 200 %0d",
               ex_valid, ex_pc, bubble_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_load_use();
    put(1'b1, LW, 32'h204, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7);
    step();
    put(1'b1, ADD, 32'h208, 5'd7, 1'b1, 5'd1, 1'b1, 5'd10);
    flush = 1'b1;
    #1;
    n_tot++;
    if (load_use_stall !== 1'b0)
      $display("FAIL flu_stall got %b want 0", load_use_stall);
    else n_pass++;
    step();
    flush = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_tot++;
    if (ex_ctrl !== BUB || bubble_cnt !== exp_cnt)
      $display("FAIL flu_bubble got ctrl=%h cnt=%0d want %h %0d",
               ex_ctrl, bubble_cnt, BUB, exp_cnt);
    else n_pass++;
    step();
    n_tot++;
    if (ex_pc !== 32'h208 || bubble_cnt !== exp_cnt)
      $display("FAIL flu_capture got pc=%h cnt=%0d want 208 %0d",
               ex_pc, bubble_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    put(1'b1, ADD, 32'h300, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11);
    hold = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    n_tot++;
    if (ex_valid !== 1'b0 || ex_ctrl !== BUB || ex_pc !== 32'h0 ||
        bubble_cnt !== 16'd0)
      $display("FAIL rmf_clear got v=%b ctrl=%h pc=%h cnt=%0d want 0 %h 0 0",
               ex_valid, ex_ctrl, ex_pc, bubble_cnt, BUB);
    else n_pass++;
    rstn = 1'b1;
    hold = 1'b0;
    exp_cnt = 16'd0;
    step();
    n_tot++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || bubble_cnt !== 16'd0)
      $display("FAIL rmf_capture got v=%b pc=%h cnt=%0d want 1 300 0",
               ex_valid, ex_pc, bubble_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    flush = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    n_tot++;
    if (bubble_cnt !== 16'hFFFF)
      $display("FAIL sat got %h want ffff", bubble_cnt);
    else n_pass++;
    flush = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    exp_cnt = 16'd0;
    test_reset();
    test_capture();
    test_idle();
    test_load_use_rs1();
    test_no_hazard();
    test_flush_hold();
    test_flush_load_use();
    test_reset_mid_flush();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
